sap_core: RTL
=============

SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data, instruction and bus width; legal values satisfy ADDR_W <= DATA_W-4.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; memory depth is 2**ADDR_W words.
REQ-003 sysclk  in  1  single clock; all state changes on its rising edge.
REQ-004 fp_clear  in  1  reset; synchronous, active-high.
REQ-005 clken  in  1  clock enable; CPU state advances only on edges where clken=1.
REQ-006 fp_prog  in  1  front-panel program mode; holds the CPU in T1.
REQ-007 fp_write  in  1  front-panel write strobe; effective only while fp_prog=1.
REQ-008 fp_adr  in  ADDR_W  front-panel memory address.
REQ-009 fp_data  in  DATA_W  front-panel write data.
REQ-010 o_out  out  DATA_W  output register.
REQ-011 halt  out  1  high after HLT executes.
REQ-012 pc_value  out  ADDR_W  program counter.
REQ-013 t_state  out  3  current T-state, encoded 1..5 for T1..T5.
REQ-014 flags  out  2  {C,Z}.

Function
REQ-015 Instruction word: opcode = bits [DATA_W-1:DATA_W-4]; operand = bits [ADDR_W-1:0].
REQ-016 Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI, 5 JMP, 6 JC, 7 JZ, E OUT, F HLT; all other opcodes are NOPs.
REQ-017 Memory is an internal 2**ADDR_W x DATA_W array: asynchronous read, synchronous write, not cleared by reset.
REQ-018 Fetch sequence: T1 MAR<=PC; T2 IR<=mem[MAR] and PC<=PC+1, wrapping from 2**ADDR_W-1 to 0.
REQ-019 LDA: T3 MAR<=operand; T4 A<=mem[MAR]; next state T1 (4 cycles).
REQ-020 ADD/SUB: T3 MAR<=operand; T4 B<=mem[MAR]; T5 A<=A+B or A-B modulo 2**DATA_W, C and Z updated; next state T1 (5 cycles).
REQ-021 C SHALL be the carry out of A+B for ADD, and the carry out of A+~B+1 for SUB (1 when A>=B unsigned).
REQ-022 Z SHALL be 1 when the ADD/SUB result is 0; only ADD and SUB modify flags.
REQ-023 STA: T3 MAR<=operand; T4 mem[MAR]<=A (4 cycles).
REQ-024 LDI: T3 A<=operand zero-extended (3 cycles); JMP: T3 PC<=operand (3 cycles); OUT: T3 o_out<=A (3 cycles); NOP: T3 no effect (3 cycles).
REQ-025 HLT: T3 sets halt; the state then freezes in T3 until reset.
REQ-026 While fp_prog=1: state forced to T1, PC/IR/A/B/flags held; when fp_write=1, mem[fp_adr]<=fp_data on each edge regardless of clken.
REQ-027 A CPU STA and a front-panel write cannot coincide, because fp_prog blocks execution.
REQ-028 When clken=0 with fp_prog=0, all registers and memory SHALL hold.

Reset
REQ-029 fp_clear=1 at an edge SHALL set PC=0, MAR=0, IR=0, o_out=0, flags=0, halt=0 and t_state=T1, regardless of clken, fp_prog or the current state.
REQ-030 A and B SHALL have no reset and retain their value; memory contents SHALL be retained.
REQ-031 Reset SHALL have priority over fp_prog, fp_write and execution; a front-panel write in the reset cycle is dropped.

Configuration
REQ-032 Macro SAP_COND_JUMP_EN defined: JC loads PC<=operand at T3 if C=1 and JZ does the same if Z=1; otherwise PC is unchanged.
REQ-033 Macro SAP_COND_JUMP_EN undefined: JC and JZ execute as 3-cycle NOPs; the flags are still computed and output.

Verification
REQ-034 Defaults. Program mem[0..3]=09,1A,E0,F0 with mem[9]=05 and mem[A]=03, clear, run clken=1 -> o_out=08 after 12 edges; halt=1 after 15 edges; flags=00.
REQ-035 SUB. mem[0..3]=4 3,2 9,E0,F0 with mem[9]=05 -> o_out=FE, C=0, Z=0; with mem[9]=03 -> o_out=00, C=1, Z=1.
REQ-036 JZ with SAP_COND_JUMP_EN. mem[0..4]=43,29,7 8 (JZ 8),E0,F0; mem[8]=F0; mem[9]=03 -> PC=8 and o_out remains 00; with the macro undefined -> OUT executes, o_out=00, PC passes through 4.
REQ-037 PC wrap: fill memory with NOP 0xD0, run 16 instructions -> pc_value goes F then 0; toggle clken 0 for 5 edges mid-T4 of LDA -> t_state and PC unchanged.
REQ-038 Reset mid-T5 of ADD, then assert fp_clear -> next edge PC=0, t_state=1, o_out=0, halt=0; A keeps its pre-reset value; memory intact.
REQ-039 fp_prog=1 with fp_write=1, fp_adr=F, fp_data=5A, clken=0 -> mem[F]=5A; t_state remains 1.

Source files
------------

// File: rtl/sap_core_if.sv
// Front-panel bus of the SAP core: programming inputs plus the status lines
// the panel displays (output register, halt lamp, PC, T-state, flags).
interface sap_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              fp_prog;
  logic              fp_write;
  logic [ADDR_W-1:0] fp_adr;
  logic [DATA_W-1:0] fp_data;
  logic [DATA_W-1:0] o_out;
  logic              halt;
  logic [ADDR_W-1:0] pc_value;
  logic [2:0]        t_state;
  logic [1:0]        flags;

  modport master (
    output fp_prog, fp_write, fp_adr, fp_data,
    input  o_out, halt, pc_value, t_state, flags
  );

  modport slave (
    input  fp_prog, fp_write, fp_adr, fp_data,
    output o_out, halt, pc_value, t_state, flags
  );
endinterface

// File: rtl/sap_core.sv
// SAP-1 style accumulator CPU with internal memory and front-panel loader.
// Define SAP_COND_JUMP_EN to make JC/JZ real conditional jumps (else NOPs).
module sap_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic       sysclk,
  input  logic       fp_clear,
  input  logic       clken,
  sap_core_if.slave  panel
);

  typedef enum logic [2:0] {
    T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
  } tstate_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_STA = 4'h3,
    OP_LDI = 4'h4, OP_JMP = 4'h5, OP_JC  = 4'h6, OP_JZ  = 4'h7,
    OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  tstate_t           state_q, state_d;
  logic [ADDR_W-1:0] pc_q, mar_q;
  logic [DATA_W-1:0] ir_q, a_q, b_q, out_q;
  logic              c_q, z_q, halt_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [3:0]        op;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] mem_rd, b_op;
  logic [DATA_W:0]   alu_sum;
  logic              is_sub, is_arith, needs_mem, take_jump, exec_ok;

  assign op       = ir_q[DATA_W-1 -: 4];
  assign operand  = ir_q[ADDR_W-1:0];
  assign mem_rd   = mem[mar_q];
  assign is_sub   = (op == OP_SUB);
  assign is_arith = (op == OP_ADD) || is_sub;
  assign needs_mem = (op == OP_LDA) || is_arith || (op == OP_STA);
  // Subtraction is A + ~B + 1, so the carry out reads as "no borrow".
  assign b_op     = is_sub ? ~b_q : b_q;
  assign alu_sum  = {1'b0, a_q} + {1'b0, b_op} + (DATA_W+1)'(is_sub);
  assign exec_ok  = !fp_clear && !panel.fp_prog && clken && !halt_q;

`ifdef SAP_COND_JUMP_EN
  assign take_jump = (op == OP_JMP) || ((op == OP_JC) && c_q) || ((op == OP_JZ) && z_q);
`else
  assign take_jump = (op == OP_JMP);
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      T1: state_d = T2;
      T2: state_d = T3;
      T3: begin
        if (needs_mem)           state_d = T4;
        else if (op == OP_HLT)   state_d = T3;
        else                     state_d = T1;
      end
      T4: state_d = is_arith ? T5 : T1;
      default: state_d = T1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (fp_clear) begin
      state_q <= T1;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      halt_q  <= 1'b0;
    end else if (panel.fp_prog) begin
      state_q <= T1;
    end else if (exec_ok) begin
      state_q <= state_d;
      case (state_q)
        T1: mar_q <= pc_q;
        T2: begin
          ir_q <= mem_rd;
          pc_q <= pc_q + ADDR_W'(1);
        end
        T3: begin
          if (needs_mem)      mar_q  <= operand;
          if (take_jump)      pc_q   <= operand;
          if (op == OP_OUT)   out_q  <= a_q;
          if (op == OP_HLT)   halt_q <= 1'b1;
        end
        T5: begin
          c_q <= alu_sum[DATA_W];
          z_q <= (alu_sum[DATA_W-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

  // Working registers keep their contents across fp_clear.
  always_ff @(posedge sysclk) begin
    if (exec_ok) begin
      case (state_q)
        T3: if (op == OP_LDI) a_q <= {{(DATA_W-ADDR_W){1'b0}}, operand};
        T4: begin
          if (op == OP_LDA) a_q <= mem_rd;
          if (is_arith)     b_q <= mem_rd;
        end
        T5: a_q <= alu_sum[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  // NOTE: the memory array has no reset; its contents survive fp_clear and it maps onto plain RAM.
  always_ff @(posedge sysclk) begin
    if (!fp_clear) begin
      if (panel.fp_prog && panel.fp_write)
        mem[panel.fp_adr] <= panel.fp_data;
      else if (exec_ok && (state_q == T4) && (op == OP_STA))
        mem[mar_q] <= a_q;
    end
  end

  assign panel.o_out    = out_q;
  assign panel.halt     = halt_q;
  assign panel.pc_value = pc_q;
  assign panel.t_state  = state_q;
  assign panel.flags    = {c_q, z_q};

endmodule
